tdm_demux_1x2: RTL and testbench

- Time-division 1-to-2 demultiplexer. It is the receive end of the 2:1 mux serializer link.
- Takes one serial bit stream in which slots alternate between channel A (even slot) and channel B (odd slot).
- Reassembles one WIDTH-bit word per channel and presents both words together, with a single-cycle valid strobe.
- Sits directly downstream of the mux_2X1-based serializer in the structural project.

---
 rtl/tdm_demux_1x2.sv | 102 ++++++++++
 tb/tb_tdm_demux_1x2.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x2.sv
// rtl/tdm_demux_1x2.sv - receive-side 1:2 TDM demultiplexer
// Rebuilds one channel A word and one channel B word from an interleaved serial stream (A on even slots).
module tdm_demux_1x2 #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  output logic             sel_o,
  output logic             busy,
  output logic             frame_err
);

  localparam int            CW   = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_a_out;
  logic [WIDTH-1:0] r_b_out;
  logic             r_out_valid;
  logic             r_sel;
  logic             r_busy;
  logic             r_frame_err;

  logic w_start;
  logic w_accept;

  // Shifting in from one end lands the first received bit at WIDTH-1 or at 0 after WIDTH beats.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v, input logic b);
    if (MSB_FIRST)
      return {v[WIDTH-2:0], b};
    else
      return {b, v[WIDTH-1:1]};
  endfunction

  assign w_start  = din_valid & frame_start;
  assign w_accept = din_valid & ~frame_start & (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sa        <= '0;
      r_sb        <= '0;
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_out_valid <= 1'b0;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      // frame_start wins over completion, so a start on the last beat aborts that frame.
      if (w_start) begin
        r_frame_err <= (r_state == RUN);
        r_sa        <= f_shift('0, din);
        r_sb        <= '0;
        r_cnt       <= CW'(1);
        r_state     <= RUN;
        r_busy      <= 1'b1;
        r_sel       <= 1'b1;
      end else if (w_accept) begin
        if (r_cnt[0] == 1'b0)
          r_sa <= f_shift(r_sa, din);
        else
          r_sb <= f_shift(r_sb, din);
        if (r_cnt == LAST) begin
          r_a_out     <= r_sa;
          r_b_out     <= f_shift(r_sb, din);
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_busy      <= 1'b0;
          r_sel       <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_sel <= ~r_cnt[0];
        end
      end
    end
  end

  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign out_valid = r_out_valid;
  assign sel_o     = r_sel;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// tb/tb_tdm_demux_1x2.sv - directed self-checking bench for tdm_demux_1x2
module tb_tdm_demux_1x2;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic [3:0] a_m, b_m, a_l, b_l;
  logic       ov_m, sel_m, busy_m, fe_m;
  logic       ov_l, sel_l, busy_l, fe_l;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, ov_n, ov_at, fe_n;

  always #5 clk = ~clk;

  tdm_demux_1x2 #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a_out(a_m), .b_out(b_m), .out_valid(ov_m), .sel_o(sel_m), .busy(busy_m), .frame_err(fe_m)
  );

  tdm_demux_1x2 #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a_out(a_l), .b_out(b_l), .out_valid(ov_l), .sel_o(sel_l), .busy(busy_l), .frame_err(fe_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic fs);
    @(negedge clk);
    din         = d;
    din_valid   = v;
    frame_start = fs;
    @(posedge clk);
    #1;
    cyc++;
    if (ov_m) begin
      ov_n++;
      ov_at = cyc;
    end
    if (fe_m) fe_n++;
  endtask

  task automatic clr_mon();
    cyc   = 0;
    ov_n  = 0;
    ov_at = 0;
    fe_n  = 0;
  endtask

  // bits[7] is the first beat; frame_start accompanies beat 0; optional stall after beat stall_at.
  task automatic send_frame(input logic [7:0] bits, input int nbeats, input int stall_at, input int stall_n);
    clr_mon();
    for (int b = 0; b < nbeats; b++) begin
      step(bits[7-b], 1'b1, b == 0);
      check("sel", 32'(sel_m), (b == 7) ? 32'd0 : 32'((b + 1) % 2));
      check("busy", 32'(busy_m), (b == 7) ? 32'd0 : 32'd1);
      if (b + 1 == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          step(1'b1, 1'b0, 1'b1);
          check("stall_sel", 32'(sel_m), 32'(stall_at % 2));
          check("stall_ov", 32'(ov_m), 32'd0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
    clr_mon();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("rst_a", 32'(a_m), 32'd0);
    check("rst_b", 32'(b_m), 32'd0);
    check("rst_ov", 32'(ov_m), 32'd0);
    check("rst_sel", 32'(sel_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_fe", 32'(fe_m), 32'd0);
    rst = 1'b0;

    step(1'b1, 1'b1, 1'b0);
    check("idle_valid_only", 32'(busy_m), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("idle_start_only", 32'(busy_m), 32'd0);
    check("idle_sel", 32'(sel_m), 32'd0);

    send_frame(8'b10011110, 8, 0, 0);
    check("t1_ov_n", 32'(ov_n), 32'd1);
    check("t1_ov_at", 32'(ov_at), 32'd8);
    check("t1_a", 32'(a_m), 32'hB);
    check("t1_b", 32'(b_m), 32'h6);
    check("t1_lsb_a", 32'(a_l), 32'hD);
    check("t1_lsb_b", 32'(b_l), 32'h6);
    step(1'b0, 1'b0, 1'b0);
    check("t1_ov_pulse", 32'(ov_m), 32'd0);
    check("t1_a_hold", 32'(a_m), 32'hB);

    send_frame(8'b10011110, 8, 4, 3);
    check("t2_ov_n", 32'(ov_n), 32'd1);
    check("t2_ov_at", 32'(ov_at), 32'd11);
    check("t2_a", 32'(a_m), 32'hB);
    check("t2_b", 32'(b_m), 32'h6);

    send_frame(8'b10011110, 5, 0, 0);
    check("t3_part_ov", 32'(ov_n), 32'd0);
    check("t3_part_fe", 32'(fe_n), 32'd0);
    send_frame(8'hFF, 8, 0, 0);
    check("t3_fe_n", 32'(fe_n), 32'd1);
    check("t3_ov_n", 32'(ov_n), 32'd1);
    check("t3_a", 32'(a_m), 32'hF);
    check("t3_b", 32'(b_m), 32'hF);

    send_frame(8'b00000000, 7, 0, 0);
    check("t4_part_ov", 32'(ov_n), 32'd0);
    check("t4_a_hold", 32'(a_m), 32'hF);
    send_frame(8'b10011110, 8, 0, 0);
    check("t4_fe_n", 32'(fe_n), 32'd1);
    check("t4_ov_n", 32'(ov_n), 32'd1);
    check("t4_a", 32'(a_m), 32'hB);
    check("t4_b", 32'(b_m), 32'h6);

    send_frame(8'b10011110, 8, 0, 0);
    check("t5_f1_ov_at", 32'(ov_at), 32'd8);
    check("t5_f1_a", 32'(a_m), 32'hB);
    send_frame(8'b01000010, 8, 0, 0);
    check("t5_f2_ov_n", 32'(ov_n), 32'd1);
    check("t5_f2_ov_at", 32'(ov_at), 32'd8);
    check("t5_f2_fe", 32'(fe_n), 32'd0);
    check("t5_f2_a", 32'(a_m), 32'h1);
    check("t5_f2_b", 32'(b_m), 32'h8);

    send_frame(8'b10011110, 5, 0, 0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("t6_rst_a", 32'(a_m), 32'd0);
    check("t6_rst_b", 32'(b_m), 32'd0);
    check("t6_rst_ov", 32'(ov_m), 32'd0);
    check("t6_rst_busy", 32'(busy_m), 32'd0);
    rst = 1'b0;
    send_frame(8'b01100110, 8, 0, 0);
    check("t6_ov_n", 32'(ov_n), 32'd1);
    check("t6_fe_n", 32'(fe_n), 32'd0);
    check("t6_a", 32'(a_m), 32'h5);
    check("t6_b", 32'(b_m), 32'hA);
    check("t6_lsb_a", 32'(a_l), 32'hA);
    check("t6_lsb_b", 32'(b_l), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
